// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_ISSUE = 3'b010,
        ST_RESP  = 3'b100
    } state_e;

    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    localparam logic [31:0] STALL_MAX = 32'hFFFF_FFFF;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == STALL_MAX) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_grant2.sv
// Two-way grant picker: bit 0 = instruction channel, bit 1 = data channel.
module rr_grant2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       prio_mode,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        // On contention: data wins in priority mode, else whoever was not granted last.
        if (req == 2'b11) begin
            if (prio_mode || (last == OWNER_INST)) begin
                gnt = 2'b10;
            end else begin
                gnt = 2'b01;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store channels, routes the
// single outstanding read back to its owner and counts contention stalls.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int DATA_PRIO = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inst_req_valid,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_req_ack,
    output logic                inst_valid,
    output logic [DATA_W-1:0]   inst_data,
    input  logic                inst_ack,
    input  logic                data_ren,
    input  logic                data_wen,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    input  logic [DATA_W/8-1:0] data_wstrb,
    output logic                data_req_ack,
    output logic                data_rvalid,
    output logic [DATA_W-1:0]   data_rdata,
    input  logic                data_rack,
    output logic                m_req_valid,
    input  logic                m_req_ready,
    output logic                m_req_wen,
    output logic [ADDR_W-1:0]   m_req_addr,
    output logic [DATA_W-1:0]   m_req_wdata,
    output logic [DATA_W/8-1:0] m_req_wstrb,
    input  logic                m_resp_valid,
    input  logic [DATA_W-1:0]   m_resp_data,
    output logic                m_resp_ready,
    output logic [31:0]         stall_cnt
);

    localparam logic PRIO_MODE = (DATA_PRIO != 0);

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic        inst_pend, data_pend, own_wr, owner_ack, stall_inc;
    logic [1:0]  gnt;

    assign inst_pend = inst_req_valid;
    assign data_pend = data_ren | data_wen;
    // A simultaneous ren/wen is treated as a store.
    assign own_wr    = (owner_q == OWNER_DATA) && data_wen;
    assign owner_ack = (owner_q == OWNER_DATA) ? data_rack : inst_ack;

    rr_grant2 u_grant (
        .req       ({data_pend, inst_pend}),
        .last      (last_q),
        .prio_mode (PRIO_MODE),
        .gnt       (gnt)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        stall_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stall_inc = inst_pend & data_pend;
                if (|gnt) begin
                    owner_d = gnt[1];
                    last_d  = gnt[1];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                stall_inc = (owner_q == OWNER_DATA) ? inst_pend : data_pend;
                if (m_req_ready) begin
                    state_d = own_wr ? ST_IDLE : ST_RESP;
                end
            end
            ST_RESP: begin
                stall_inc = (owner_q == OWNER_DATA) ? inst_pend : data_pend;
                if (m_resp_valid && owner_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        stall_cnt_d = stall_inc ? sat_inc(stall_cnt_q) : stall_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWNER_INST;
            last_q      <= OWNER_DATA;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Outputs are forced low while reset is asserted, not only after the edge.
    always_comb begin
        inst_req_ack = 1'b0;
        inst_valid   = 1'b0;
        inst_data    = '0;
        data_req_ack = 1'b0;
        data_rvalid  = 1'b0;
        data_rdata   = '0;
        m_req_valid  = 1'b0;
        m_req_wen    = 1'b0;
        m_req_addr   = '0;
        m_req_wdata  = '0;
        m_req_wstrb  = '0;
        m_resp_ready = 1'b0;
        stall_cnt    = '0;
        if (rst) begin
            stall_cnt = stall_cnt_q;
            case (state_q)
                ST_ISSUE: begin
                    m_req_valid = 1'b1;
                    m_req_wen   = own_wr;
                    m_req_addr  = (owner_q == OWNER_DATA) ? data_addr : inst_addr;
                    if (own_wr) begin
                        m_req_wdata = data_wdata;
                        m_req_wstrb = data_wstrb;
                    end
                    if (owner_q == OWNER_DATA) begin
                        data_req_ack = m_req_ready;
                    end else begin
                        inst_req_ack = m_req_ready;
                    end
                end
                ST_RESP: begin
                    m_resp_ready = owner_ack;
                    if (owner_q == OWNER_DATA) begin
                        data_rvalid = m_resp_valid;
                        data_rdata  = m_resp_data;
                    end else begin
                        inst_valid = m_resp_valid;
                        inst_data  = m_resp_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter (priority and round-robin instances).
module tb_mem_port_arbiter;

    typedef struct {
        bit          own;
        bit          wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct {
        bit          own;
        logic [31:0] data;
    } rd_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        inst_req_valid, inst_ack;
    logic [31:0] inst_addr;
    logic        data_ren, data_wen, data_rack;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        m_req_ready, m_resp_valid;
    logic [31:0] m_resp_data;

    logic        p_inst_req_ack, p_inst_valid, p_data_req_ack, p_data_rvalid;
    logic        p_m_req_valid, p_m_req_wen, p_m_resp_ready;
    logic [31:0] p_inst_data, p_data_rdata, p_m_req_addr, p_m_req_wdata, p_stall_cnt;
    logic [3:0]  p_m_req_wstrb;
    logic        r_inst_req_ack, r_inst_valid, r_data_req_ack, r_data_rvalid;
    logic        r_m_req_valid, r_m_req_wen, r_m_resp_ready;
    logic [31:0] r_inst_data, r_data_rdata, r_m_req_addr, r_m_req_wdata, r_stall_cnt;
    logic [3:0]  r_m_req_wstrb;

    logic        o_inst_req_ack, o_inst_valid, o_data_req_ack, o_data_rvalid;
    logic        o_m_req_valid, o_m_req_wen, o_m_resp_ready;
    logic [31:0] o_inst_data, o_data_rdata, o_m_req_addr, o_m_req_wdata, o_stall_cnt;
    logic [3:0]  o_m_req_wstrb;
    logic        sel_rr;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_PRIO(1)) u_prio (
        .clk(clk), .rst(rst),
        .inst_req_valid(inst_req_valid), .inst_addr(inst_addr), .inst_req_ack(p_inst_req_ack),
        .inst_valid(p_inst_valid), .inst_data(p_inst_data), .inst_ack(inst_ack),
        .data_ren(data_ren), .data_wen(data_wen), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_wstrb(data_wstrb), .data_req_ack(p_data_req_ack),
        .data_rvalid(p_data_rvalid), .data_rdata(p_data_rdata), .data_rack(data_rack),
        .m_req_valid(p_m_req_valid), .m_req_ready(m_req_ready), .m_req_wen(p_m_req_wen),
        .m_req_addr(p_m_req_addr), .m_req_wdata(p_m_req_wdata), .m_req_wstrb(p_m_req_wstrb),
        .m_resp_valid(m_resp_valid), .m_resp_data(m_resp_data), .m_resp_ready(p_m_resp_ready),
        .stall_cnt(p_stall_cnt)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_PRIO(0)) u_rr (
        .clk(clk), .rst(rst),
        .inst_req_valid(inst_req_valid), .inst_addr(inst_addr), .inst_req_ack(r_inst_req_ack),
        .inst_valid(r_inst_valid), .inst_data(r_inst_data), .inst_ack(inst_ack),
        .data_ren(data_ren), .data_wen(data_wen), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_wstrb(data_wstrb), .data_req_ack(r_data_req_ack),
        .data_rvalid(r_data_rvalid), .data_rdata(r_data_rdata), .data_rack(data_rack),
        .m_req_valid(r_m_req_valid), .m_req_ready(m_req_ready), .m_req_wen(r_m_req_wen),
        .m_req_addr(r_m_req_addr), .m_req_wdata(r_m_req_wdata), .m_req_wstrb(r_m_req_wstrb),
        .m_resp_valid(m_resp_valid), .m_resp_data(m_resp_data), .m_resp_ready(r_m_resp_ready),
        .stall_cnt(r_stall_cnt)
    );

    always_comb begin
        o_inst_req_ack = sel_rr ? r_inst_req_ack : p_inst_req_ack;
        o_inst_valid   = sel_rr ? r_inst_valid   : p_inst_valid;
        o_inst_data    = sel_rr ? r_inst_data    : p_inst_data;
        o_data_req_ack = sel_rr ? r_data_req_ack : p_data_req_ack;
        o_data_rvalid  = sel_rr ? r_data_rvalid  : p_data_rvalid;
        o_data_rdata   = sel_rr ? r_data_rdata   : p_data_rdata;
        o_m_req_valid  = sel_rr ? r_m_req_valid  : p_m_req_valid;
        o_m_req_wen    = sel_rr ? r_m_req_wen    : p_m_req_wen;
        o_m_req_addr   = sel_rr ? r_m_req_addr   : p_m_req_addr;
        o_m_req_wdata  = sel_rr ? r_m_req_wdata  : p_m_req_wdata;
        o_m_req_wstrb  = sel_rr ? r_m_req_wstrb  : p_m_req_wstrb;
        o_m_resp_ready = sel_rr ? r_m_resp_ready : p_m_resp_ready;
        o_stall_cnt    = sel_rr ? r_stall_cnt    : p_stall_cnt;
    end

    int   total = 0;
    int   bad   = 0;
    req_t req_q[$];
    rd_t  rd_q[$];
    logic ack_i, ack_d;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_req(input bit own, input bit wen, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wstrb);
        req_t r;
        r.own = own; r.wen = wen; r.addr = addr; r.wdata = wdata; r.wstrb = wstrb;
        req_q.push_back(r);
    endtask

    task automatic push_rd(input bit own, input logic [31:0] data);
        rd_t r;
        r.own = own; r.data = data;
        rd_q.push_back(r);
    endtask

    // Move to mid-cycle and score any handshake the selected DUT shows.
    task automatic smp();
        req_t er;
        rd_t  ed;
        #4;
        ack_i = o_inst_req_ack;
        ack_d = o_data_req_ack;
        if (o_m_req_valid && m_req_ready) begin
            total++;
            assert (req_q.size() != 0) else begin
                bad++;
                $error("FAIL req_unexpected observed=handshake addr=%0h expected=none", o_m_req_addr);
            end
            if (req_q.size() != 0) begin
                er = req_q.pop_front();
                chk("req_ack_owner", 64'({o_inst_req_ack, o_data_req_ack}), er.own ? 64'd1 : 64'd2);
                chk("req_wen", 64'(o_m_req_wen), 64'(er.wen));
                chk("req_addr", 64'(o_m_req_addr), 64'(er.addr));
                chk("req_wdata", 64'(o_m_req_wdata), 64'(er.wdata));
                chk("req_wstrb", 64'(o_m_req_wstrb), 64'(er.wstrb));
            end
        end else begin
            chk("req_ack_quiet", 64'({o_inst_req_ack, o_data_req_ack}), 64'd0);
        end
        if ((o_inst_valid && inst_ack) || (o_data_rvalid && data_rack)) begin
            total++;
            assert (rd_q.size() != 0) else begin
                bad++;
                $error("FAIL rd_unexpected observed=inst:%0b data:%0b expected=none", o_inst_valid, o_data_rvalid);
            end
            if (rd_q.size() != 0) begin
                ed = rd_q.pop_front();
                chk("rd_port", 64'({o_inst_valid, o_data_rvalid}), ed.own ? 64'd1 : 64'd2);
                chk("rd_data", 64'(ed.own ? o_data_rdata : o_inst_data), 64'(ed.data));
                chk("rd_resp_ready", 64'(o_m_resp_ready), 64'd1);
            end
        end
    endtask

    // Advance past the next rising edge; requesters drop after being accepted.
    task automatic adv();
        @(posedge clk);
        #1;
        if (ack_i) inst_req_valid = 1'b0;
        if (ack_d) begin
            data_ren = 1'b0;
            data_wen = 1'b0;
        end
    endtask

    task automatic cyc();
        smp();
        adv();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, 64'({o_inst_req_ack, o_inst_valid, o_data_req_ack, o_data_rvalid,
                                 o_m_req_valid, o_m_req_wen, o_m_resp_ready}), 64'd0);
        chk({tag, "_bus"}, 64'(|{o_inst_data, o_data_rdata, o_m_req_addr, o_m_req_wdata, o_m_req_wstrb}), 64'd0);
        chk({tag, "_stall"}, 64'(o_stall_cnt), 64'd0);
    endtask

    initial begin
        rst = 1'b0; sel_rr = 1'b0;
        inst_req_valid = 1'b0; inst_addr = '0; inst_ack = 1'b0;
        data_ren = 1'b0; data_wen = 1'b0; data_addr = '0; data_wdata = '0; data_wstrb = '0; data_rack = 1'b0;
        m_req_ready = 1'b0; m_resp_valid = 1'b0; m_resp_data = '0;
        ack_i = 1'b0; ack_d = 1'b0;
        adv();
        smp(); chk_all_zero("reset_prio"); adv();
        rst = 1'b1;
        cyc();

        // Fetch only
        inst_req_valid = 1'b1; inst_addr = 32'h100; m_req_ready = 1'b1;
        push_req(1'b0, 1'b0, 32'h100, 32'h0, 4'h0);
        smp(); chk("fetch_grant_latency", 64'(o_m_req_valid), 64'd0); adv();
        cyc();
        m_resp_valid = 1'b1; m_resp_data = 32'h0000_0013; inst_ack = 1'b1;
        push_rd(1'b0, 32'h0000_0013);
        cyc();
        m_resp_valid = 1'b0; inst_ack = 1'b0;
        smp(); chk("fetch_valid_one_cycle", 64'(o_inst_valid), 64'd0); adv();

        // Store completes at accept, no response phase
        data_wen = 1'b1; data_addr = 32'h2004; data_wdata = 32'hDEAD_BEEF; data_wstrb = 4'b1100;
        push_req(1'b1, 1'b1, 32'h2004, 32'hDEAD_BEEF, 4'b1100);
        cyc();
        cyc();
        m_resp_valid = 1'b1; m_resp_data = 32'hBAD0_BAD0; data_rack = 1'b1;
        smp();
        chk("store_no_resp_valid", 64'(o_data_rvalid), 64'd0);
        chk("store_no_resp_ready", 64'(o_m_resp_ready), 64'd0);
        chk("store_back_idle", 64'(o_m_req_valid), 64'd0);
        adv();
        m_resp_valid = 1'b0; data_rack = 1'b0;

        // Contention with data priority, 2-cycle read latency
        inst_req_valid = 1'b1; inst_addr = 32'h200;
        data_ren = 1'b1; data_addr = 32'h3000;
        push_req(1'b1, 1'b0, 32'h3000, 32'h0, 4'h0);
        push_req(1'b0, 1'b0, 32'h200, 32'h0, 4'h0);
        cyc();
        cyc();
        cyc();
        m_resp_valid = 1'b1; m_resp_data = 32'hCAFE_0001; data_rack = 1'b1;
        push_rd(1'b1, 32'hCAFE_0001);
        cyc();
        m_resp_valid = 1'b0; data_rack = 1'b0;
        smp(); chk("contend_stall", 64'(o_stall_cnt), 64'd4); adv();
        cyc();
        m_resp_valid = 1'b1; m_resp_data = 32'h0000_0093; inst_ack = 1'b1;
        push_rd(1'b0, 32'h0000_0093);
        cyc();
        m_resp_valid = 1'b0; inst_ack = 1'b0;
        smp(); chk("contend_stall_final", 64'(o_stall_cnt), 64'd4); adv();

        // Request and response backpressure
        inst_req_valid = 1'b1; inst_addr = 32'h400; m_req_ready = 1'b0;
        push_req(1'b0, 1'b0, 32'h400, 32'h0, 4'h0);
        cyc();
        for (int i = 0; i < 5; i++) begin
            smp();
            chk("bp_req_valid", 64'(o_m_req_valid), 64'd1);
            chk("bp_req_addr", 64'(o_m_req_addr), 64'h400);
            chk("bp_no_ack", 64'(o_inst_req_ack), 64'd0);
            adv();
        end
        m_req_ready = 1'b1;
        cyc();
        m_resp_valid = 1'b1; m_resp_data = 32'h55; inst_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            smp();
            chk("bp_resp_ready_low", 64'(o_m_resp_ready), 64'd0);
            chk("bp_resp_held", 64'(o_inst_valid), 64'd1);
            adv();
        end
        inst_ack = 1'b1;
        push_rd(1'b0, 32'h55);
        cyc();
        m_resp_valid = 1'b0; inst_ack = 1'b0;

        // Reset while a read is outstanding
        inst_req_valid = 1'b1; inst_addr = 32'h500;
        push_req(1'b0, 1'b0, 32'h500, 32'h0, 4'h0);
        cyc();
        cyc();
        rst = 1'b0; m_resp_valid = 1'b1; m_resp_data = 32'h0000_0BAD; inst_ack = 1'b1;
        smp(); chk_all_zero("reset_mid_resp"); adv();
        rst = 1'b1;
        smp();
        chk("stray_resp_valid", 64'(o_inst_valid), 64'd0);
        chk("stray_resp_ready", 64'(o_m_resp_ready), 64'd0);
        chk("stray_req_valid", 64'(o_m_req_valid), 64'd0);
        chk("post_reset_stall", 64'(o_stall_cnt), 64'd0);
        adv();
        m_resp_valid = 1'b0; inst_ack = 1'b0;
        inst_req_valid = 1'b1; inst_addr = 32'h600;
        push_req(1'b0, 1'b0, 32'h600, 32'h0, 4'h0);
        cyc();
        cyc();
        m_resp_valid = 1'b1; m_resp_data = 32'h0000_006F; inst_ack = 1'b1;
        push_rd(1'b0, 32'h0000_006F);
        cyc();
        m_resp_valid = 1'b0; inst_ack = 1'b0;

        // Round-robin instance, both requesters pending
        sel_rr = 1'b1; rst = 1'b0;
        smp(); chk_all_zero("reset_rr"); adv();
        rst = 1'b1;
        inst_ack = 1'b1; data_rack = 1'b1;
        inst_req_valid = 1'b1; inst_addr = 32'h1000;
        data_ren = 1'b1; data_addr = 32'h5000;
        push_req(1'b0, 1'b0, 32'h1000, 32'h0, 4'h0);
        push_req(1'b1, 1'b0, 32'h5000, 32'h0, 4'h0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            cyc();
            m_resp_valid = 1'b1; m_resp_data = 32'hA0 + 32'(k);
            push_rd(k[0], 32'hA0 + 32'(k));
            cyc();
            m_resp_valid = 1'b0;
            if (k == 0) begin
                inst_req_valid = 1'b1; inst_addr = 32'h1004;
                push_req(1'b0, 1'b0, 32'h1004, 32'h0, 4'h0);
            end
            if (k == 1) begin
                data_ren = 1'b1; data_addr = 32'h5004;
                push_req(1'b1, 1'b0, 32'h5004, 32'h0, 4'h0);
            end
        end
        smp();
        chk("rr_stall", 64'(o_stall_cnt), 64'd9);
        chk("rr_idle", 64'(o_m_req_valid), 64'd0);
        adv();

        chk("req_q_drained", 64'(req_q.size()), 64'd0);
        chk("rd_q_drained", 64'(rd_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
